// File: rtl/resnet_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : resnet_sched_pkg
//  Description : Shared types and default widths for the ResNet stream scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package resnet_sched_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_CNT_W  = 20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sched_state_e;

    typedef enum logic {
        STR_IN  = 1'b0,
        STR_KER = 1'b1
    } stream_id_e;

endpackage
`default_nettype wire

// File: rtl/stream_prefetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : stream_prefetch_fifo
//  Description : Small prefetch FIFO with a same-cycle readable head.
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_prefetch_fifo #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clear,
    input  logic                            push,
    input  logic [DATA_W-1:0]               push_data,
    input  logic                            pop,
    output logic [DATA_W-1:0]               head,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
    output logic                            empty,
    output logic                            underflow
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW    = $clog2(FIFO_DEPTH + 1);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] last_q, last_d;
    logic              w_pop_ok;
    logic              w_push_ok;
    logic              w_full;

    always_comb begin
        w_full    = (count_q == CW'(FIFO_DEPTH));
        w_pop_ok  = pop && (count_q != '0);
        w_push_ok = push && !clear && (!w_full || w_pop_ok);
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        last_d    = last_q;
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push_ok) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            // Remember the popped word so an empty FIFO keeps presenting it.
            if (w_pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                last_d   = mem_q[rd_ptr_q];
            end
            if (w_push_ok && !w_pop_ok) begin
                count_d = count_q + CW'(1);
            end else if (w_pop_ok && !w_push_ok) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head      = empty ? last_q : mem_q[rd_ptr_q];
    assign underflow = pop && empty;

endmodule
`default_nettype wire

// File: rtl/resnet_stream_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : resnet_stream_scheduler
//  Description : Round-robin prefetch of input/kernel streams from one memory port.
//  Revision    : 1.0 - initial release
// ============================================================================
module resnet_stream_scheduler
    import resnet_sched_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int FIFO_DEPTH = 4,
    parameter int MEM_LAT    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_in_base,
    input  logic [ADDR_W-1:0] cfg_ker_base,
    input  logic [CNT_W-1:0]  cfg_in_words,
    input  logic [CNT_W-1:0]  cfg_ker_words,
    input  logic [CNT_W-1:0]  cfg_out_words,
    input  logic              in_rd_en,
    input  logic              ker_rd_en,
    output logic [DATA_W-1:0] in_rd_data,
    output logic [DATA_W-1:0] ker_rd_data,
    input  logic              out_wr_valid,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              underflow_err
);
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W  = $clog2(FIFO_DEPTH + MEM_LAT + 2) + 1;

    sched_state_e      state_q, state_d;
    stream_id_e        last_q, last_d;
    stream_id_e        req_id_q, req_id_d;
    logic [ADDR_W-1:0] in_base_q, in_base_d, ker_base_q, ker_base_d;
    logic [CNT_W-1:0]  in_words_q, in_words_d, ker_words_q, ker_words_d;
    logic [CNT_W-1:0]  out_words_q, out_words_d, out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0]  fetched_in_q, fetched_in_d, fetched_ker_q, fetched_ker_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [MEM_LAT-1:0] tag_vld_q, tag_vld_d, tag_id_q, tag_id_d;
    logic              underflow_q, underflow_d;

    logic              w_start_ok, w_active;
    logic [ADDR_W-1:0] w_eff_in_base, w_eff_ker_base, w_req_addr;
    logic [CNT_W-1:0]  w_eff_in_words, w_eff_ker_words;
    logic [CNT_W-1:0]  w_eff_fetched_in, w_eff_fetched_ker;
    stream_id_e        w_eff_last, w_grant;
    logic              w_grant_vld, w_elig_in, w_elig_ker;
    logic [OCC_W-1:0]  w_infl_in, w_infl_ker, w_occ_in, w_occ_ker;
    logic [FCNT_W-1:0] w_in_count, w_ker_count;
    logic              w_in_empty, w_ker_empty, w_in_uf, w_ker_uf;
    logic              w_in_push, w_ker_push;

    // Outstanding words per stream: issue stage plus every tag still in flight.
    always_comb begin
        w_infl_in  = '0;
        w_infl_ker = '0;
        if (mem_req_q) begin
            if (req_id_q == STR_IN) w_infl_in  = w_infl_in + OCC_W'(1);
            else                    w_infl_ker = w_infl_ker + OCC_W'(1);
        end
        for (int i = 0; i < MEM_LAT; i++) begin
            if (tag_vld_q[i]) begin
                if (tag_id_q[i] == logic'(STR_IN)) w_infl_in  = w_infl_in + OCC_W'(1);
                else                               w_infl_ker = w_infl_ker + OCC_W'(1);
            end
        end
    end

    always_comb begin
        w_start_ok        = start && !flush && (state_q != RUN);
        w_active          = !flush && ((state_q == RUN) || w_start_ok);
        w_eff_in_base     = w_start_ok ? cfg_in_base   : in_base_q;
        w_eff_ker_base    = w_start_ok ? cfg_ker_base  : ker_base_q;
        w_eff_in_words    = w_start_ok ? cfg_in_words  : in_words_q;
        w_eff_ker_words   = w_start_ok ? cfg_ker_words : ker_words_q;
        w_eff_fetched_in  = w_start_ok ? '0 : fetched_in_q;
        w_eff_fetched_ker = w_start_ok ? '0 : fetched_ker_q;
        w_eff_last        = w_start_ok ? STR_KER : last_q;
        // A pop in this cycle frees its slot before the new request can land.
        w_occ_in   = OCC_W'(w_in_count) + w_infl_in - OCC_W'(in_rd_en && !w_in_empty);
        w_occ_ker  = OCC_W'(w_ker_count) + w_infl_ker - OCC_W'(ker_rd_en && !w_ker_empty);
        w_elig_in  = w_active && (w_eff_fetched_in < w_eff_in_words)
                     && (w_occ_in < OCC_W'(FIFO_DEPTH));
        w_elig_ker = w_active && (w_eff_fetched_ker < w_eff_ker_words)
                     && (w_occ_ker < OCC_W'(FIFO_DEPTH));
        w_grant_vld = w_elig_in || w_elig_ker;
        if (w_elig_in && w_elig_ker) begin
            w_grant = (w_eff_last == STR_IN) ? STR_KER : STR_IN;
        end else begin
            w_grant = w_elig_in ? STR_IN : STR_KER;
        end
        w_req_addr = (w_grant == STR_IN) ? (w_eff_in_base + ADDR_W'(w_eff_fetched_in))
                                         : (w_eff_ker_base + ADDR_W'(w_eff_fetched_ker));
    end

    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        in_base_d     = in_base_q;
        ker_base_d    = ker_base_q;
        in_words_d    = in_words_q;
        ker_words_d   = ker_words_q;
        out_words_d   = out_words_q;
        out_cnt_d     = out_cnt_q;
        fetched_in_d  = fetched_in_q;
        fetched_ker_d = fetched_ker_q;
        mem_req_d     = 1'b0;
        mem_addr_d    = mem_addr_q;
        req_id_d      = req_id_q;
        tag_vld_d     = (tag_vld_q << 1) | MEM_LAT'(mem_req_q);
        tag_id_d      = (tag_id_q << 1) | MEM_LAT'(req_id_q);
        underflow_d   = underflow_q;
        if (flush) begin
            state_d       = IDLE;
            last_d        = STR_KER;
            out_cnt_d     = '0;
            fetched_in_d  = '0;
            fetched_ker_d = '0;
            mem_addr_d    = '0;
            tag_vld_d     = '0;
        end else begin
            if (w_start_ok) begin
                state_d       = RUN;
                last_d        = STR_KER;
                in_base_d     = cfg_in_base;
                ker_base_d    = cfg_ker_base;
                in_words_d    = cfg_in_words;
                ker_words_d   = cfg_ker_words;
                out_words_d   = cfg_out_words;
                out_cnt_d     = '0;
                fetched_in_d  = '0;
                fetched_ker_d = '0;
                underflow_d   = 1'b0;
            end else if (state_q == RUN) begin
                out_cnt_d = out_cnt_q + CNT_W'(out_wr_valid);
                if (out_cnt_d >= out_words_q) state_d = DONE;
            end
            if (w_grant_vld) begin
                mem_req_d  = 1'b1;
                mem_addr_d = w_req_addr;
                req_id_d   = w_grant;
                last_d     = w_grant;
                if (w_grant == STR_IN) fetched_in_d  = w_eff_fetched_in + CNT_W'(1);
                else                   fetched_ker_d = w_eff_fetched_ker + CNT_W'(1);
            end
        end
        if (w_in_uf || w_ker_uf) underflow_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            last_q        <= STR_KER;
            req_id_q      <= STR_IN;
            in_base_q     <= '0;
            ker_base_q    <= '0;
            in_words_q    <= '0;
            ker_words_q   <= '0;
            out_words_q   <= '0;
            out_cnt_q     <= '0;
            fetched_in_q  <= '0;
            fetched_ker_q <= '0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            tag_vld_q     <= '0;
            tag_id_q      <= '0;
            underflow_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            req_id_q      <= req_id_d;
            in_base_q     <= in_base_d;
            ker_base_q    <= ker_base_d;
            in_words_q    <= in_words_d;
            ker_words_q   <= ker_words_d;
            out_words_q   <= out_words_d;
            out_cnt_q     <= out_cnt_d;
            fetched_in_q  <= fetched_in_d;
            fetched_ker_q <= fetched_ker_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            tag_vld_q     <= tag_vld_d;
            tag_id_q      <= tag_id_d;
            underflow_q   <= underflow_d;
        end
    end

    assign w_in_push  = tag_vld_q[MEM_LAT-1] && (tag_id_q[MEM_LAT-1] == logic'(STR_IN));
    assign w_ker_push = tag_vld_q[MEM_LAT-1] && (tag_id_q[MEM_LAT-1] == logic'(STR_KER));

    stream_prefetch_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_in_fifo (
        .clk(clk), .rst(rst), .clear(flush),
        .push(w_in_push), .push_data(mem_rdata), .pop(in_rd_en),
        .head(in_rd_data), .count(w_in_count), .empty(w_in_empty), .underflow(w_in_uf)
    );

    stream_prefetch_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_ker_fifo (
        .clk(clk), .rst(rst), .clear(flush),
        .push(w_ker_push), .push_data(mem_rdata), .pop(ker_rd_en),
        .head(ker_rd_data), .count(w_ker_count), .empty(w_ker_empty), .underflow(w_ker_uf)
    );

    assign mem_req       = mem_req_q;
    assign mem_addr      = mem_addr_q;
    assign busy          = (state_q == RUN);
    assign done          = (state_q == DONE);
    assign underflow_err = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_resnet_stream_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_resnet_stream_scheduler
//  Description : Self-checking bench with a queue-based stream scheduler model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_resnet_stream_scheduler;
    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 16;
    localparam int CNT_W      = 20;
    localparam int FIFO_DEPTH = 4;
    localparam int MEM_LAT    = 2;

    logic              clk = 1'b0;
    logic              rst, flush, start;
    logic [ADDR_W-1:0] cfg_in_base, cfg_ker_base;
    logic [CNT_W-1:0]  cfg_in_words, cfg_ker_words, cfg_out_words;
    logic              in_rd_en, ker_rd_en, out_wr_valid;
    logic [DATA_W-1:0] in_rd_data, ker_rd_data, mem_rdata;
    logic              mem_req, busy, done, underflow_err;
    logic [ADDR_W-1:0] mem_addr;

    resnet_stream_scheduler #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W),
        .FIFO_DEPTH(FIFO_DEPTH), .MEM_LAT(MEM_LAT)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .start(start),
        .cfg_in_base(cfg_in_base), .cfg_ker_base(cfg_ker_base),
        .cfg_in_words(cfg_in_words), .cfg_ker_words(cfg_ker_words),
        .cfg_out_words(cfg_out_words),
        .in_rd_en(in_rd_en), .ker_rd_en(ker_rd_en),
        .in_rd_data(in_rd_data), .ker_rd_data(ker_rd_data),
        .out_wr_valid(out_wr_valid),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] pat(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h3C5A;
    endfunction

    // Fixed-latency memory: data for the address presented MEM_LAT cycles ago.
    logic [15:0] mp_a [MEM_LAT];
    always @(posedge clk) begin
        mp_a[0] <= mem_addr;
        for (int i = 1; i < MEM_LAT; i++) mp_a[i] <= mp_a[i-1];
    end
    assign mem_rdata = pat(mp_a[MEM_LAT-1]);

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: each stream keeps a queue of every word requested but not yet
    // popped, tagged with the cycle it becomes visible at the FIFO head.
    typedef struct { logic [15:0] d; int vis; } ent_t;
    ent_t        q_in[$], q_ker[$];
    int          cyc;
    int          m_state, m_last, m_req_in, m_req_ker, m_out_cnt, m_out_words;
    int          m_words_in, m_words_ker;
    logic [15:0] m_base_in, m_base_ker, m_last_in, m_last_ker, exp_addr;
    bit          m_uf, exp_req;
    int          obs_reqs;
    logic [15:0] obs_addrs[$];

    function automatic bit ne_in();
        return (q_in.size() > 0) && (q_in[0].vis <= cyc);
    endfunction
    function automatic bit ne_ker();
        return (q_ker.size() > 0) && (q_ker[0].vis <= cyc);
    endfunction

    task automatic model_reset();
        q_in.delete(); q_ker.delete();
        m_state = 0; m_last = 1; m_req_in = 0; m_req_ker = 0; m_out_cnt = 0;
        m_uf = 0; m_last_in = '0; m_last_ker = '0; exp_req = 0; exp_addr = '0;
    endtask

    task automatic model_update();
        bit          uf_set, start_ok, was_run, el_in, el_ker;
        int          g;
        logic [15:0] a;
        uf_set = 0;
        if (in_rd_en) begin
            if (ne_in()) begin m_last_in = q_in[0].d; void'(q_in.pop_front()); end
            else uf_set = 1;
        end
        if (ker_rd_en) begin
            if (ne_ker()) begin m_last_ker = q_ker[0].d; void'(q_ker.pop_front()); end
            else uf_set = 1;
        end
        was_run  = (m_state == 1);
        start_ok = start && !flush && !was_run;
        exp_req  = 0;
        if (flush) begin
            q_in.delete(); q_ker.delete();
            m_state = 0; m_req_in = 0; m_req_ker = 0; m_out_cnt = 0; m_last = 1;
            exp_addr = '0;
        end else begin
            if (start_ok) begin
                m_base_in = cfg_in_base; m_base_ker = cfg_ker_base;
                m_words_in = int'(cfg_in_words); m_words_ker = int'(cfg_ker_words);
                m_out_words = int'(cfg_out_words);
                m_req_in = 0; m_req_ker = 0; m_out_cnt = 0; m_uf = 0; m_state = 1; m_last = 1;
            end else if (was_run) begin
                if (out_wr_valid) m_out_cnt++;
                if (m_out_cnt >= m_out_words) m_state = 2;
            end
            el_in  = (was_run || start_ok) && (m_req_in < m_words_in) && (q_in.size() < FIFO_DEPTH);
            el_ker = (was_run || start_ok) && (m_req_ker < m_words_ker) && (q_ker.size() < FIFO_DEPTH);
            if (el_in && el_ker) g = (m_last == 0) ? 1 : 0;
            else                 g = el_in ? 0 : 1;
            if (el_in || el_ker) begin
                exp_req = 1;
                if (g == 0) begin
                    a = m_base_in + 16'(m_req_in);
                    m_req_in++;
                    q_in.push_back('{d: pat(a), vis: cyc + MEM_LAT + 2});
                end else begin
                    a = m_base_ker + 16'(m_req_ker);
                    m_req_ker++;
                    q_ker.push_back('{d: pat(a), vis: cyc + MEM_LAT + 2});
                end
                exp_addr = a;
                m_last = g;
            end
        end
        if (uf_set) m_uf = 1;
    endtask

    task automatic check_all();
        chk("mem_req", 32'(mem_req), 32'(exp_req));
        chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
        chk("busy", 32'(busy), 32'(m_state == 1));
        chk("done", 32'(done), 32'(m_state == 2));
        chk("underflow_err", 32'(underflow_err), 32'(m_uf));
        chk("in_rd_data", 32'(in_rd_data), 32'(ne_in() ? q_in[0].d : m_last_in));
        chk("ker_rd_data", 32'(ker_rd_data), 32'(ne_ker() ? q_ker[0].d : m_last_ker));
        if (mem_req) begin
            obs_reqs++;
            obs_addrs.push_back(mem_addr);
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
        cyc++;
        check_all();
        start = 0;
        flush = 0;
    endtask

    // pop_mode: 0 never, 1 whenever the model holds a visible word
    task automatic run(input int n, input int pop_mode, input int owv_pct);
        for (int i = 0; i < n; i++) begin
            in_rd_en     = (pop_mode == 1) && ne_in();
            ker_rd_en    = (pop_mode == 1) && ne_ker();
            out_wr_valid = ($urandom_range(99) < owv_pct);
            tick();
        end
        in_rd_en = 0; ker_rd_en = 0; out_wr_valid = 0;
    endtask

    task automatic launch(input logic [15:0] ib, input int iw, input logic [15:0] kb,
                          input int kw, input int ow);
        cfg_in_base = ib; cfg_in_words = CNT_W'(iw);
        cfg_ker_base = kb; cfg_ker_words = CNT_W'(kw);
        cfg_out_words = CNT_W'(ow);
        start = 1;
        tick();
    endtask

    task automatic do_flush();
        in_rd_en = 0; ker_rd_en = 0; out_wr_valid = 0;
        flush = 1;
        tick();
    endtask

    initial begin
        rst = 1; flush = 0; start = 0; in_rd_en = 0; ker_rd_en = 0; out_wr_valid = 0;
        cfg_in_base = '0; cfg_ker_base = '0; cfg_in_words = '0; cfg_ker_words = '0;
        cfg_out_words = '0;
        cyc = 0; obs_reqs = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 0;

        // Two interleaved streams, done after the 4th output strobe
        obs_reqs = 0;
        launch(16'h0100, 8, 16'h0200, 8, 4);
        run(40, 1, 25);
        chk("t1_total_reqs", 32'(obs_reqs), 32'd16);
        chk("t1_first_addr", 32'(obs_addrs[0]), 32'h0100);
        chk("t1_second_addr", 32'(obs_addrs[1]), 32'h0200);

        // No pops: exactly FIFO_DEPTH requests, then one pop releases one more
        obs_reqs = 0;
        launch(16'h0300, 16, 16'h0400, 0, 100);
        run(15, 0, 0);
        chk("nopop_reqs", 32'(obs_reqs), 32'(FIFO_DEPTH));
        in_rd_en = 1;
        tick();
        in_rd_en = 0;
        run(10, 0, 0);
        chk("nopop_release", 32'(obs_reqs), 32'(FIFO_DEPTH + 1));
        do_flush();

        // Continuous popping of a single stream
        launch(16'h0500, 12, 16'h0000, 0, 100);
        run(30, 1, 0);
        do_flush();

        // Pop on empty ker FIFO in the first RUN cycle; next start clears the flag
        launch(16'h0600, 4, 16'h0700, 4, 3);
        ker_rd_en = 1;
        tick();
        ker_rd_en = 0;
        chk("uf_sticky", 32'(underflow_err), 32'd1);
        run(30, 1, 50);
        launch(16'h0600, 2, 16'h0700, 2, 2);
        chk("uf_cleared", 32'(underflow_err), 32'd0);
        run(20, 1, 50);

        // Flush with requests in flight, then refetch from base
        launch(16'h0800, 8, 16'h0900, 8, 50);
        run(2, 0, 0);
        do_flush();
        chk("flush_idle", 32'(busy), 32'd0);
        in_rd_en = 1; ker_rd_en = 1;
        tick();
        in_rd_en = 0; ker_rd_en = 0;
        run(5, 0, 0);
        obs_addrs.delete();
        launch(16'h0800, 8, 16'h0900, 8, 6);
        chk("refetch_base", 32'(obs_addrs[0]), 32'h0800);
        run(40, 1, 30);
        do_flush();

        // Address wrap-around
        obs_addrs.delete();
        launch(16'hFFFE, 4, 16'h0000, 0, 2);
        run(20, 1, 50);
        chk("wrap_a0", 32'(obs_addrs[0]), 32'hFFFE);
        chk("wrap_a1", 32'(obs_addrs[1]), 32'hFFFF);
        chk("wrap_a2", 32'(obs_addrs[2]), 32'h0000);
        chk("wrap_a3", 32'(obs_addrs[3]), 32'h0001);
        do_flush();

        // Randomized traffic with an asynchronous reset in the middle
        for (int i = 0; i < 1500; i++) begin
            int r;
            if (i == 1000) begin
                #2 rst = 1;
                model_reset();
                #1 check_all();
                @(negedge clk);
                rst = 0;
            end
            r = int'($urandom_range(99));
            if (r < 2) begin
                flush = 1;
            end else if (r < 7) begin
                cfg_in_base   = 16'($urandom_range(65535));
                cfg_ker_base  = 16'($urandom_range(65535));
                cfg_in_words  = CNT_W'($urandom_range(12));
                cfg_ker_words = CNT_W'($urandom_range(12));
                cfg_out_words = CNT_W'($urandom_range(20));
                start = 1;
            end
            in_rd_en     = !flush && ($urandom_range(99) < 60);
            ker_rd_en    = !flush && ($urandom_range(99) < 60);
            out_wr_valid = ($urandom_range(99) < 30);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
